// File: rtl/r_rom_backend.sv
// Remote-ROM responder: collects a little-endian address from the command FIFO,
// issues one memory read, and streams the result LSB-first into the response FIFO.
module r_rom_backend #(
  parameter int ADDR_BYTES = 8,
  parameter int DATA_BYTES = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    c_empty_i,
  output logic                    c_rd_en_o,
  input  logic [7:0]              c_dout_i,
  input  logic                    r_full_i,
  output logic                    r_wr_en_o,
  output logic [7:0]              r_din_o,
  output logic                    mem_req_o,
  output logic [8*ADDR_BYTES-1:0] mem_addr_o,
  input  logic                    mem_ack_i,
  input  logic [8*DATA_BYTES-1:0] mem_rdata_i,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = $clog2(ADDR_BYTES + 1);
  localparam int SW = $clog2(DATA_BYTES + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LOAD_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [CW-1:0] ADDR_BYTES_C = CW'(ADDR_BYTES);
  localparam logic [CW-1:0] ADDR_LAST_C  = CW'(ADDR_BYTES - 1);
  localparam logic [SW-1:0] DATA_LAST_C  = SW'(DATA_BYTES - 1);
  localparam logic [TW-1:0] TO_LOAD_C    = TW'(TO_LOAD_I);

  typedef enum logic [1:0] {S_CMD, S_REQ, S_RSP} state_e;

  state_e          state_q;
  logic            started_q;
  logic            rd_v_q;
  logic            mem_req_q;
  logic [CW-1:0]   issued_q;
  logic [CW-1:0]   got_q;
  logic [SW-1:0]   sent_q;
  logic [TW-1:0]   wait_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            wait_done_d;

  // started_q keeps every output quiet for the first cycle after reset release
  assign c_rd_en_o   = started_q && (state_q == S_CMD) && !c_empty_i && (issued_q < ADDR_BYTES_C);
  assign r_wr_en_o   = (state_q == S_RSP) && !r_full_i;
  assign r_din_o     = data_q[7:0];
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = addr_q;
  assign wait_done_d = (TIMEOUT != 0) && (wait_q == '0);
  assign timeout_o   = (state_q == S_REQ) && wait_done_d && !mem_ack_i;
  assign busy_o      = (state_q != S_CMD) || (got_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_CMD;
      started_q <= 1'b0;
      rd_v_q    <= 1'b0;
      mem_req_q <= 1'b0;
      issued_q  <= '0;
      got_q     <= '0;
      sent_q    <= '0;
      wait_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      started_q <= 1'b1;
      rd_v_q    <= c_rd_en_o;
      case (state_q)
        S_CMD: begin
          if (c_rd_en_o) issued_q <= issued_q + 1'b1;
          if (rd_v_q) begin
            addr_q <= {c_dout_i, addr_q[AW-1:8]};
            if (got_q == ADDR_LAST_C) begin
              got_q     <= '0;
              issued_q  <= '0;
              mem_req_q <= 1'b1;
              wait_q    <= TO_LOAD_C;
              state_q   <= S_REQ;
            end else begin
              got_q <= got_q + 1'b1;
            end
          end
        end
        S_REQ: begin
          // an ack coincident with the terminal count takes priority
          if (mem_ack_i) begin
            data_q    <= mem_rdata_i;
            mem_req_q <= 1'b0;
            state_q   <= S_RSP;
          end else if (wait_done_d) begin
            data_q    <= '1;
            mem_req_q <= 1'b0;
            state_q   <= S_RSP;
          end else if (TIMEOUT != 0) begin
            wait_q <= wait_q - 1'b1;
          end
        end
        S_RSP: begin
          if (r_wr_en_o) begin
            data_q <= data_q >> 8;
            if (sent_q == DATA_LAST_C) begin
              sent_q  <= '0;
              state_q <= S_CMD;
            end else begin
              sent_q <= sent_q + 1'b1;
            end
          end
        end
        default: state_q <= S_CMD;
      endcase
    end
  end

endmodule
